cfg_stream_loader: RTL and testbench

- Upstream configuration sequencer for one tile. It accepts the tile bitstream as bytes over a valid/ready handshake from the host or programming port.
- It serialises the bytes LSB-first and distributes the bits in fixed order to the CLB, switch block and connection block serial ports (bit_in, bit_in_SB, bit_in_CB).
- It drives the global prgm_b and the per-target shift enables clb_prgm_b, sb_prgm_b and cb_prgm_b.
- It replaces bench-side shifting logic, so a tile is programmed by hardware alone.

---
 rtl/cfg_loader_pkg.sv | 20 ++
 rtl/cfg_word_serializer.sv | 55 +++++
 rtl/cfg_stream_loader.sv | 150 +++++++++++++++
 tb/tb_cfg_stream_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared types and default chain lengths for the tile configuration loader.
// Holds the loader FSM state encoding and the segment-length constants.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CLB,
    LOAD_SB,
    LOAD_CB,
    FINISH
  } state_t;

  localparam int CLB_BITS   = 296;
  localparam int SB_BITS    = 384;
  localparam int CB_BITS    = 104;
  localparam int TOTAL_BITS = CLB_BITS + SB_BITS + CB_BITS;
  localparam int WORD_W     = 8;
  localparam int CNT_W      = 9;

endpackage

// File: rtl/cfg_word_serializer.sv
// Single-word buffer that turns accepted words into a serial bit stream, LSB first.
// Ports: clk, reset_b, active/consume/flush controls, in_data/in_valid/in_ready, bit_valid, bit_out.
module cfg_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              active,
  input  logic              consume,
  input  logic              flush,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_valid,
  output logic              bit_out
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic              full_q;
  logic              last;
  logic              take;

  assign last      = (idx_q == LAST);
  // Refill on the same edge the final bit leaves so words stream back to back.
  assign in_ready  = active && (!full_q || (last && consume));
  assign take      = in_valid && in_ready;
  assign bit_valid = full_q;
  assign bit_out   = word_q[idx_q];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (flush) begin
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (take) begin
      word_q <= in_data;
      idx_q  <= '0;
      full_q <= 1'b1;
    end else if (consume) begin
      if (last) begin
        full_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_stream_loader.sv
// Tile configuration sequencer: streams words into CLB, SB and CB shift chains in order.
// Ports: clk, reset_b, start, in_data/in_valid/in_ready, prgm_b, {clb,sb,cb}_bit/_prgm_b, busy, done, bit_cnt.
module cfg_stream_loader
  import cfg_loader_pkg::*;
#(
  parameter int CLB_BITS = cfg_loader_pkg::CLB_BITS,
  parameter int SB_BITS  = cfg_loader_pkg::SB_BITS,
  parameter int CB_BITS  = cfg_loader_pkg::CB_BITS,
  parameter int WORD_W   = cfg_loader_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              prgm_b,
  output logic              clb_bit,
  output logic              clb_prgm_b,
  output logic              sb_bit,
  output logic              sb_prgm_b,
  output logic              cb_bit,
  output logic              cb_prgm_b,
  output logic              busy,
  output logic              done,
  output logic [8:0]        bit_cnt
);

  state_t     state_q;
  state_t     next_seg;
  logic [8:0] seg_max;
  logic       in_load;
  logic       is_clb;
  logic       is_sb;
  logic       is_cb;
  logic       bit_valid;
  logic       bit_out;
  logic       emit;
  logic       active;
  logic       flush;
  logic       seg_end;

  assign is_clb  = (state_q == LOAD_CLB);
  assign is_sb   = (state_q == LOAD_SB);
  assign is_cb   = (state_q == LOAD_CB);
  assign in_load = is_clb || is_sb || is_cb;
  assign active  = busy && (state_q != FINISH);
  assign flush   = (state_q == FINISH);
  assign emit    = in_load && bit_valid;
  assign seg_end = (bit_cnt == seg_max);

  always_comb begin
    seg_max  = 9'(CLB_BITS - 1);
    next_seg = LOAD_SB;
    unique case (1'b1)
      is_sb: begin
        seg_max  = 9'(SB_BITS - 1);
        next_seg = LOAD_CB;
      end
      is_cb: begin
        seg_max  = 9'(CB_BITS - 1);
        next_seg = FINISH;
      end
      default: begin
        seg_max  = 9'(CLB_BITS - 1);
        next_seg = LOAD_SB;
      end
    endcase
  end

  cfg_word_serializer #(
    .WORD_W(WORD_W)
  ) u_ser (
    .clk      (clk),
    .reset_b  (reset_b),
    .active   (active),
    .consume  (emit),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bit_valid(bit_valid),
    .bit_out  (bit_out)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      prgm_b     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      clb_bit    <= 1'b0;
      sb_bit     <= 1'b0;
      cb_bit     <= 1'b0;
      clb_prgm_b <= 1'b0;
      sb_prgm_b  <= 1'b0;
      cb_prgm_b  <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      // Enables are strobes: a target shifts only on edges where one is set.
      clb_prgm_b <= 1'b0;
      sb_prgm_b  <= 1'b0;
      cb_prgm_b  <= 1'b0;
      done       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD_CLB;
            prgm_b  <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        LOAD_CLB, LOAD_SB, LOAD_CB: begin
          if (emit) begin
            unique case (1'b1)
              is_clb: begin
                clb_bit    <= bit_out;
                clb_prgm_b <= 1'b1;
              end
              is_sb: begin
                sb_bit    <= bit_out;
                sb_prgm_b <= 1'b1;
              end
              is_cb: begin
                cb_bit    <= bit_out;
                cb_prgm_b <= 1'b1;
              end
              default: ;
            endcase
            if (seg_end) begin
              bit_cnt <= '0;
              state_q <= next_seg;
            end else begin
              bit_cnt <= bit_cnt + 9'd1;
            end
          end
        end
        FINISH: begin
          prgm_b  <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Scoreboard bench for cfg_stream_loader: expected bits queued on word acceptance,
// popped by a negedge monitor whenever a target shift enable is high.
module tb_cfg_stream_loader;

  localparam int CLB = 296;
  localparam int SB  = 384;
  localparam int CB  = 104;
  localparam int TOT = 784;
  localparam int NW  = 98;

  typedef struct packed {
    logic [1:0] tgt;
    logic       b;
    logic [8:0] cnt;
  } exp_t;

  logic       clk = 0;
  logic       reset_b = 1;
  logic       rst300_n = 1;
  logic       start = 0;
  logic       in_valid = 0;
  logic [7:0] in_data = 0;

  logic       in_ready, prgm_b, busy, done;
  logic       clb_bit, clb_prgm_b, sb_bit, sb_prgm_b, cb_bit, cb_prgm_b;
  logic [8:0] bit_cnt;

  logic       x_in_ready, x_prgm_b, x_busy, x_done;
  logic       x_clb_bit, x_clb_en, x_sb_bit, x_sb_en, x_cb_bit, x_cb_en;
  logic [8:0] x_bit_cnt;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   pushed = 0;
  int   emitted = 0;
  int   gaps = 0;
  int   done_cnt = 0;
  int   n300 = 0;

  always #5 clk = ~clk;

  cfg_stream_loader dut (
    .clk(clk), .reset_b(reset_b), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .prgm_b(prgm_b),
    .clb_bit(clb_bit), .clb_prgm_b(clb_prgm_b),
    .sb_bit(sb_bit), .sb_prgm_b(sb_prgm_b),
    .cb_bit(cb_bit), .cb_prgm_b(cb_prgm_b),
    .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  cfg_stream_loader #(.CLB_BITS(300)) dut300 (
    .clk(clk), .reset_b(reset_b && rst300_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(x_in_ready),
    .prgm_b(x_prgm_b),
    .clb_bit(x_clb_bit), .clb_prgm_b(x_clb_en),
    .sb_bit(x_sb_bit), .sb_prgm_b(x_sb_en),
    .cb_bit(x_cb_bit), .cb_prgm_b(x_cb_en),
    .busy(x_busy), .done(x_done), .bit_cnt(x_bit_cnt)
  );

  function automatic exp_t mk(int n, logic b);
    exp_t e;
    int   base;
    int   len;
    if (n < CLB) begin
      e.tgt = 2'd0; base = 0; len = CLB;
    end else if (n < CLB + SB) begin
      e.tgt = 2'd1; base = CLB; len = SB;
    end else begin
      e.tgt = 2'd2; base = CLB + SB; len = CB;
    end
    e.b   = b;
    e.cnt = (n - base + 1 == len) ? 9'd0 : 9'(n - base + 1);
    return e;
  endfunction

  function automatic logic [1:0] en2tgt(logic [2:0] en);
    case (en)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_prgm_b"}, 32'(prgm_b), 1);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_in_ready"}, 32'(in_ready), 0);
    chk({nm, "_enables"}, 32'({cb_prgm_b, sb_prgm_b, clb_prgm_b}), 0);
    chk({nm, "_bits"}, 32'({cb_bit, sb_bit, clb_bit}), 0);
    chk({nm, "_bit_cnt"}, 32'(bit_cnt), 0);
  endtask

  task automatic monitor();
    logic [2:0] en;
    logic       bv;
    logic [1:0] tg;
    bit         last_now;
    bit         prev_last;
    exp_t       e;
    prev_last = 0;
    forever begin
      @(negedge clk);
      en = {cb_prgm_b, sb_prgm_b, clb_prgm_b};
      last_now = 0;
      if (en != 3'b000) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL stray_bit: en=%b with no expected bit", en);
        end else begin
          e  = q.pop_front();
          bv = en[0] ? clb_bit : (en[1] ? sb_bit : cb_bit);
          tg = en2tgt(en);
          if (tg != e.tgt || bv !== e.b || bit_cnt !== e.cnt || prgm_b !== 1'b0) begin
            mismatched++;
            $display("FAIL bit[%0d]: tgt=%0d bit=%b cnt=%0d prgm_b=%b expected tgt=%0d bit=%b cnt=%0d prgm_b=0",
                     emitted, tg, bv, bit_cnt, prgm_b, e.tgt, e.b, e.cnt);
          end
        end
        emitted++;
        last_now = (emitted == TOT);
      end else if (busy && emitted > 0 && emitted < TOT) begin
        gaps++;
      end
      if (done === 1'b1) begin
        compared++;
        done_cnt++;
        if (!prev_last || prgm_b !== 1'b1 || busy !== 1'b0) begin
          mismatched++;
          $display("FAIL done_timing: after_last=%0d prgm_b=%b busy=%b expected 1 1 0",
                   prev_last, prgm_b, busy);
        end
      end
      prev_last = last_now;
    end
  endtask

  task automatic monitor300();
    logic [2:0] en;
    logic [7:0] w;
    logic       bv;
    logic [1:0] et;
    forever begin
      @(negedge clk);
      en = {x_cb_en, x_sb_en, x_clb_en};
      if (rst300_n && en != 3'b000) begin
        w  = 8'hA5 + 8'(n300 / 8);
        et = (n300 < 300) ? 2'd0 : ((n300 < 684) ? 2'd1 : 2'd2);
        bv = en[0] ? x_clb_bit : (en[1] ? x_sb_bit : x_cb_bit);
        compared++;
        if (en2tgt(en) != et || bv !== w[n300 % 8]) begin
          mismatched++;
          $display("FAIL clb300_bit[%0d]: tgt=%0d bit=%b expected tgt=%0d bit=%b",
                   n300, en2tgt(en), bv, et, w[n300 % 8]);
        end
        n300++;
      end
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: in_ready=0 expected 1");
    end else begin
      for (int b = 0; b < 8; b++) begin
        q.push_back(mk(pushed, w[b]));
        pushed++;
      end
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_load(input int nwords, input int stall_at,
                          input int start_at, input int exp_gaps,
                          input bit pre_started, input bit b2b);
    int t;
    pushed = 0;
    emitted = 0;
    gaps = 0;
    done_cnt = 0;
    if (!pre_started) begin
      start = 1;
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < nwords; i++) begin
      if (i == stall_at) begin
        t = 0;
        while (!in_ready && t < 50) begin
          @(negedge clk);
          t++;
        end
        in_valid = 0;
        repeat (3) @(negedge clk);
      end
      if (i == start_at) start = 1;
      send_word(8'hA5 + 8'(i));
    end
    in_valid = 0;
    if (nwords < NW) return;
    t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: done=%b expected 1", done);
    end
    if (b2b) start = 1;
    @(negedge clk);
    start = 0;
    chk("done_pulses", done_cnt, 1);
    chk("enabled_edges", emitted, TOT);
    chk("stall_gaps", gaps, exp_gaps);
    chk("queue_left", q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      monitor300();
    join_none
    #2 reset_b = 0;
    in_valid = 1;
    #1 check_reset("por");
    repeat (2) @(negedge clk);
    reset_b = 1;
    @(negedge clk);
    check_reset("idle_valid");

    run_load(NW, -1, -1, 0, 0, 0);
    chk("clb300_bits", n300, TOT);
    rst300_n = 0;

    run_load(NW, 37, 60, 3, 0, 1);
    run_load(NW, -1, -1, 0, 1, 0);

    run_load(40, -1, -1, 0, 0, 0);
    in_valid = 1;
    #2 reset_b = 0;
    #1 check_reset("mid_reset");
    q.delete();
    repeat (2) @(negedge clk);
    reset_b = 1;
    repeat (3) @(negedge clk);
    check_reset("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
